umi_demux_reg: RTL and testbench
================================

Name: umi_demux_reg

Overview:
- Registered 1-to-M UMI packet demultiplexer.
- Takes one UMI input stream and forwards each packet to the output ports named by a per-packet select mask.
- Holds each packet in a single output stage until every selected output has accepted it.
- Sits between a UMI host port and M downstream UMI clients; the select is normally decoded from dstaddr bits upstream.

Parameters:
- M, 4, number of output ports (>=1)
- DW, 256, UMI data width
- CW, 32, UMI command width
- AW, 64, UMI address width

Ports:
- clk  input  1  clock, all state on rising edge
- nreset  input  1  asynchronous active-low reset
- select  input  M  destination mask, sampled with the input packet; bit i targets output i
- umi_in_valid  input  1  input packet valid
- umi_in_cmd  input  CW  input command
- umi_in_dstaddr  input  AW  input destination address
- umi_in_srcaddr  input  AW  input source address
- umi_in_data  input  DW  input data
- umi_in_ready  output  1  input accept
- umi_out_valid  output  M  per-port valid
- umi_out_cmd  output  M*CW  per-port command, port i at [i*CW +: CW]
- umi_out_dstaddr  output  M*AW  per-port dstaddr, slice i*AW
- umi_out_srcaddr  output  M*AW  per-port srcaddr, slice i*AW
- umi_out_data  output  M*DW  per-port data, slice i*DW
- umi_out_ready  input  M  per-port accept

Behaviour:
- Clocking and reset: one clock (clk); reset nreset is asynchronous, active-low.
- State:
  - one payload register (cmd, dstaddr, srcaddr, data);
  - pending mask pend[M-1:0].
- Reset values: pend=0, so umi_out_valid=0. Payload registers reset to 0.
- umi_in_ready is combinational and is high when all of the following hold:
  - nreset is high;
  - the stage drains this cycle, i.e. (pend & ~umi_out_ready) == 0.
  - An empty stage therefore always accepts.
- Input handshake occurs when umi_in_valid & umi_in_ready at a rising edge. On handshake:
  - payload <= input fields;
  - pend <= select.
  - Latency: 1 cycle from handshake to umi_out_valid.
- Output valid: umi_out_valid[i] = pend[i].
- Output data: all M payload buses are driven from the shared payload register, whether or not the port is valid.
- Output handshake on port i is pend[i] & umi_out_ready[i]; it clears pend[i] at the edge, unless a new packet loads pend in the same edge.
- Multi-hot select broadcasts the packet. Each port handshakes independently and in any order. The next input is blocked until every pending bit clears or clears this cycle.
- Full throughput: with all selected readies high, one packet per cycle, back-to-back, no bubble.
- select == 0 with umi_in_valid: the packet is accepted (handshake completes) and discarded; pend stays 0.
- Simultaneous drain and load: the new pend value (select) wins over the clear.
- A valid input is not required to be held stable while umi_in_ready is low. Packets are only captured on a handshake.
- umi_out_valid[i] never drops until umi_out_ready[i] is seen, and the payload is stable while any pend bit is set.
- Reset mid-packet: pend clears immediately and asynchronously, and the in-flight packet is lost. umi_in_ready is low while nreset is low.

Optional Feature:
- Macro: UMI_DEMUX_REG_NOSEL_ERR_EN.
- When defined:
  - adds output port err_noselect (1 bit, after umi_out_ready);
  - err_noselect is a sticky flag, reset 0, set at the edge where a handshake occurs with select == 0;
  - it stays set until reset;
  - the packet is still dropped.
- When undefined: the port does not exist, and select == 0 packets are silently dropped.

Test Plan:
- Reset then idle: hold nreset=0 -> umi_out_valid=0, umi_in_ready=0. Release -> umi_in_ready=1.
- Single routed packet:
  - stimulus: select=4'b0100, dstaddr=64'h0000_0400_0000_0000, data pattern A5, all out_ready=1;
  - response: umi_out_valid=4'b0100 exactly one cycle later for one cycle, payload on slice 2 matches the input.
- Backpressure:
  - stimulus: select=4'b0001, umi_out_ready=0 for 5 cycles, then 1;
  - response: out_valid[0] held 5+ cycles with stable payload, umi_in_ready=0 during the stall, a second packet is accepted in the drain cycle.
- Broadcast:
  - stimulus: select=4'b1011, ready[0] high at t, ready[1] at t+2, ready[3] at t+4;
  - response: pend goes 1011 -> 1010 -> 1000 -> 0000; the next packet is accepted only at t+4.
- Throughput: 100 random packets to random one-hot selects with all readies high -> 100 packets out in 101 cycles, per-port order preserved.
- No select: select=0, valid=1 -> handshake completes, no out_valid. With UMI_DEMUX_REG_NOSEL_ERR_EN, err_noselect=1 from the next cycle onward.

Source files
------------

// File: rtl/umi_demux_reg.sv
// umi_demux_reg: registered 1-to-M UMI demultiplexer. One shared payload stage drains to every selected port.
// Optional UMI_DEMUX_REG_NOSEL_ERR_EN adds a sticky err_noselect flag for packets accepted with select == 0.
module umi_demux_reg #(
   parameter int M  = 4,
   parameter int DW = 256,
   parameter int CW = 32,
   parameter int AW = 64
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [M-1:0]    select,
   input  logic            umi_in_valid,
   input  logic [CW-1:0]   umi_in_cmd,
   input  logic [AW-1:0]   umi_in_dstaddr,
   input  logic [AW-1:0]   umi_in_srcaddr,
   input  logic [DW-1:0]   umi_in_data,
   output logic            umi_in_ready,
   output logic [M-1:0]    umi_out_valid,
   output logic [M*CW-1:0] umi_out_cmd,
   output logic [M*AW-1:0] umi_out_dstaddr,
   output logic [M*AW-1:0] umi_out_srcaddr,
   output logic [M*DW-1:0] umi_out_data,
   input  logic [M-1:0]    umi_out_ready
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
   ,
   output logic            err_noselect
`endif
);
   logic [M-1:0]  pend;
   logic [CW-1:0] cmd_r;
   logic [AW-1:0] dst_r;
   logic [AW-1:0] src_r;
   logic [DW-1:0] data_r;
   logic          hs;
   // accept whenever every pending port drains this cycle
   assign umi_in_ready = nreset & ~|(pend & ~umi_out_ready);
   assign hs = umi_in_valid & umi_in_ready;
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         pend   <= '0;
         cmd_r  <= '0;
         dst_r  <= '0;
         src_r  <= '0;
         data_r <= '0;
      end else begin
         pend <= hs ? select : pend & ~umi_out_ready;
         if (hs) begin
            cmd_r  <= umi_in_cmd;
            dst_r  <= umi_in_dstaddr;
            src_r  <= umi_in_srcaddr;
            data_r <= umi_in_data;
         end
      end
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
   always_ff @(posedge clk or negedge nreset)
      if (!nreset)
         err_noselect <= 1'b0;
      else if (hs && select == '0)
         err_noselect <= 1'b1;
`endif
   assign umi_out_valid   = pend;
   assign umi_out_cmd     = {M{cmd_r}};
   assign umi_out_dstaddr = {M{dst_r}};
   assign umi_out_srcaddr = {M{src_r}};
   assign umi_out_data    = {M{data_r}};
endmodule

// File: tb/tb_umi_demux_reg.sv
// tb_umi_demux_reg: per-port queue scoreboard checked every cycle, plus directed literal checks.
module tb_umi_demux_reg;
   localparam int M = 4, DW = 256, CW = 32, AW = 64;
   typedef struct packed {
      logic [CW-1:0] cmd;
      logic [AW-1:0] dst;
      logic [AW-1:0] src;
      logic [DW-1:0] data;
   } pkt_t;
   logic            clk = 0;
   logic            nreset = 0;
   logic [M-1:0]    select = '0;
   logic            umi_in_valid = 0;
   logic [CW-1:0]   umi_in_cmd = '0;
   logic [AW-1:0]   umi_in_dstaddr = '0;
   logic [AW-1:0]   umi_in_srcaddr = '0;
   logic [DW-1:0]   umi_in_data = '0;
   logic            umi_in_ready;
   logic [M-1:0]    umi_out_valid;
   logic [M*CW-1:0] umi_out_cmd;
   logic [M*AW-1:0] umi_out_dstaddr;
   logic [M*AW-1:0] umi_out_srcaddr;
   logic [M*DW-1:0] umi_out_data;
   logic [M-1:0]    umi_out_ready = '0;
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
   logic            err_noselect;
   bit              err_exp;
`endif
   int   checks = 0, errors = 0, nout = 0;
   pkt_t q[M][$];
   logic [M-1:0] ev;
   bit   er;

   umi_demux_reg #(.M(M), .DW(DW), .CW(CW), .AW(AW)) dut (
      .clk(clk), .nreset(nreset), .select(select),
      .umi_in_valid(umi_in_valid), .umi_in_cmd(umi_in_cmd),
      .umi_in_dstaddr(umi_in_dstaddr), .umi_in_srcaddr(umi_in_srcaddr),
      .umi_in_data(umi_in_data), .umi_in_ready(umi_in_ready),
      .umi_out_valid(umi_out_valid), .umi_out_cmd(umi_out_cmd),
      .umi_out_dstaddr(umi_out_dstaddr), .umi_out_srcaddr(umi_out_srcaddr),
      .umi_out_data(umi_out_data), .umi_out_ready(umi_out_ready)
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
      , .err_noselect(err_noselect)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Scoreboard: each selected port holds its own FIFO of packets; ready means every non-empty port drains now.
   always @(negedge clk) begin
      if (!nreset) begin
         for (int i = 0; i < M; i++) q[i].delete();
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
         err_exp = 0;
`endif
         chk("m_rst_valid", umi_out_valid, 0);
         chk("m_rst_ready", umi_in_ready, 0);
      end else begin
         er = 1;
         for (int i = 0; i < M; i++) begin
            ev[i] = q[i].size() != 0;
            if (ev[i] && !umi_out_ready[i]) er = 0;
         end
         chk("m_valid", umi_out_valid, ev);
         chk("m_ready", umi_in_ready, er);
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
         chk("m_err", err_noselect, err_exp);
`endif
         for (int i = 0; i < M; i++)
            if (ev[i]) begin
               chk("m_cmd", umi_out_cmd[i*CW +: CW], q[i][0].cmd);
               chk("m_dst", umi_out_dstaddr[i*AW +: AW], q[i][0].dst);
               chk("m_src", umi_out_srcaddr[i*AW +: AW], q[i][0].src);
               chk("m_data", umi_out_data[i*DW +: DW], q[i][0].data);
               if (umi_out_ready[i]) begin
                  void'(q[i].pop_front());
                  nout++;
               end
            end
         if (umi_in_valid && er) begin
            for (int i = 0; i < M; i++)
               if (select[i]) q[i].push_back({umi_in_cmd, umi_in_dstaddr, umi_in_srcaddr, umi_in_data});
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
            if (select == 0) err_exp = 1;
`endif
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [M-1:0] sel, input logic [DW-1:0] d, input logic [AW-1:0] dst);
      umi_in_valid   = v;
      select         = sel;
      umi_in_data    = d;
      umi_in_dstaddr = dst;
      umi_in_cmd     = $urandom;
      umi_in_srcaddr = {$urandom, $urandom};
   endtask

   initial begin
      int n0;
      logic [M-1:0] s;
      cyc(); cyc();
      chk("rst_valid", umi_out_valid, 0);
      chk("rst_ready", umi_in_ready, 0);
      nreset = 1;
      #1 chk("idle_ready", umi_in_ready, 1);
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
      chk("idle_err", err_noselect, 0);
`endif
      // single routed packet
      umi_out_ready = 4'b1111;
      drive(1, 4'b0100, {32{8'hA5}}, 64'h0000_0400_0000_0000);
      cyc();
      drive(0, 0, 0, 0);
      chk("single_valid", umi_out_valid, 4'b0100);
      chk("single_dst", umi_out_dstaddr[2*AW +: AW], 64'h0000_0400_0000_0000);
      chk("single_data", umi_out_data[2*DW +: DW], {32{8'hA5}});
      cyc();
      chk("single_gone", umi_out_valid, 0);
      // backpressure on port 0, second packet waits then enters on the drain cycle
      umi_out_ready = 0;
      drive(1, 4'b0001, {8{32'h1111_2222}}, 64'h10);
      cyc();
      drive(1, 4'b0010, {8{32'h3333_4444}}, 64'h20);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", umi_out_valid, 4'b0001);
         chk("bp_ready", umi_in_ready, 0);
         chk("bp_data", umi_out_data[0 +: DW], {8{32'h1111_2222}});
         cyc();
      end
      umi_out_ready = 4'b1111;
      #1 chk("bp_drain_ready", umi_in_ready, 1);
      cyc();
      drive(0, 0, 0, 0);
      chk("bp_second", umi_out_valid, 4'b0010);
      chk("bp_second_data", umi_out_data[DW +: DW], {8{32'h3333_4444}});
      cyc();
      // broadcast with staggered readies
      umi_out_ready = 0;
      drive(1, 4'b1011, {8{32'hB0B0_CAFE}}, 64'h30);
      cyc();
      drive(1, 4'b0100, {8{32'h0D0D_F00D}}, 64'h40);
      chk("bc_pend0", umi_out_valid, 4'b1011);
      umi_out_ready = 4'b0001;
      #1 chk("bc_block0", umi_in_ready, 0);
      cyc();
      chk("bc_pend1", umi_out_valid, 4'b1010);
      umi_out_ready = 0;
      cyc();
      umi_out_ready = 4'b0010;
      #1 chk("bc_block2", umi_in_ready, 0);
      cyc();
      chk("bc_pend2", umi_out_valid, 4'b1000);
      umi_out_ready = 0;
      cyc();
      umi_out_ready = 4'b1000;
      #1 chk("bc_accept4", umi_in_ready, 1);
      cyc();
      chk("bc_next", umi_out_valid, 4'b0100);
      drive(0, 0, 0, 0);
      umi_out_ready = 4'b1111;
      cyc();
      // throughput: 100 one-hot packets back-to-back
      n0 = nout;
      for (int k = 0; k < 100; k++) begin
         s = 4'b0001 << $urandom_range(0, 3);
         drive(1, s, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, k}, {$urandom, $urandom});
         cyc();
      end
      drive(0, 0, 0, 0);
      cyc();
      chk("tp_count", nout - n0, 100);
      chk("tp_idle", umi_out_valid, 0);
      // select == 0 is accepted and dropped
      drive(1, 0, {8{32'hDEAD_BEEF}}, 64'h50);
      #1 chk("nosel_ready", umi_in_ready, 1);
      cyc();
      drive(0, 0, 0, 0);
      chk("nosel_valid", umi_out_valid, 0);
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
      chk("nosel_err", err_noselect, 1);
      cyc();
      chk("nosel_err_sticky", err_noselect, 1);
`endif
      // asynchronous reset mid-packet
      umi_out_ready = 0;
      drive(1, 4'b0110, {8{32'h5555_AAAA}}, 64'h60);
      cyc();
      drive(0, 0, 0, 0);
      chk("rm_valid", umi_out_valid, 4'b0110);
      nreset = 0;
      #1 chk("rm_async_valid", umi_out_valid, 0);
      chk("rm_async_ready", umi_in_ready, 0);
      cyc();
      nreset = 1;
      umi_out_ready = 4'b1111;
      cyc();
      chk("rm_after", umi_out_valid, 0);
`ifdef UMI_DEMUX_REG_NOSEL_ERR_EN
      chk("rm_err", err_noselect, 0);
`endif
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
